// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back data cache.
// Geometry defaults, derived field widths and the miss FSM encoding.
package dcache_pkg;

  localparam int LINES      = 8;
  localparam int LINE_BYTES = 16;

  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int INDEX_W  = $clog2(LINES);
  localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    ALLOCATE   = 2'd2,
    REFILL     = 2'd3
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: one combinational read port and
// one synchronous write port (word store or whole-line fill).
module dcache_array #(
  parameter int LINES = dcache_pkg::LINES,
  parameter int OW    = dcache_pkg::OFFSET_W,
  parameter int IW    = dcache_pkg::INDEX_W,
  parameter int TW    = dcache_pkg::TAG_W,
  localparam int WS   = OW - 2,
  localparam int LW   = 8 << OW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] rd_idx,
  output logic          rd_valid,
  output logic          rd_dirty,
  output logic [TW-1:0] rd_tag,
  output logic [LW-1:0] rd_line,
  input  logic          store,
  input  logic          fill,
  input  logic [IW-1:0] wr_idx,
  input  logic [WS-1:0] wr_word,
  input  logic [31:0]   wr_data,
  input  logic [TW-1:0] fill_tag,
  input  logic [LW-1:0] fill_line
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [LW-1:0]    data_q [LINES];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= 1'b0;
    end else if (store) begin
      dirty_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; valid bits guard them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[wr_idx]  <= fill_tag;
      data_q[wr_idx] <= fill_line;
    end else if (store) begin
      data_q[wr_idx][{wr_word, 5'd0} +: 32] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// MEM-stage data cache controller: hit path, miss FSM
// (write-back / allocate / refill) and access counters.
module dcache_ctrl #(
  parameter int LINES      = dcache_pkg::LINES,
  parameter int LINE_BYTES = dcache_pkg::LINE_BYTES,
  localparam int OW        = $clog2(LINE_BYTES),
  localparam int IW        = $clog2(LINES),
  localparam int TW        = 32 - OW - IW,
  localparam int WS        = OW - 2,
  localparam int LW        = 8 * LINE_BYTES
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [31:0]   cpu_addr_i,
  input  logic [31:0]   cpu_wdata_i,
  output logic [31:0]   cpu_rdata_o,
  output logic          cpu_stall_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [31:0]   mem_addr_o,
  output logic [LW-1:0] mem_wdata_o,
  input  logic [LW-1:0] mem_rdata_i,
  input  logic          mem_ack_i,
  output logic [31:0]   hit_cnt_o,
  output logic [31:0]   miss_cnt_o
);

  import dcache_pkg::*;

  state_t state;

  logic [TW-1:0]    req_tag;
  logic [IW-1:0]    req_idx;
  logic [WS-1:0]    req_word;
  logic [TW+IW-1:0] miss_line_q;

  logic          rd_valid;
  logic          rd_dirty;
  logic [TW-1:0] rd_tag;
  logic [LW-1:0] rd_line;

  logic hit;
  logic store;
  logic fill;
  logic unused;

  assign req_tag  = cpu_addr_i[31 -: TW];
  assign req_idx  = cpu_addr_i[OW +: IW];
  assign req_word = cpu_addr_i[OW-1:2];
  assign unused   = ^cpu_addr_i[1:0];

  assign hit = cpu_req_i & rd_valid & (rd_tag == req_tag)
             & (state == IDLE);

  assign store = rst_i & hit & cpu_we_i;
  assign fill  = rst_i & (state == ALLOCATE) & mem_ack_i;

  assign cpu_stall_o = rst_i
                     & ((cpu_req_i & ~hit) | (state != IDLE));
  assign cpu_rdata_o = rst_i ? rd_line[{req_word, 5'd0} +: 32]
                             : 32'd0;

  dcache_array #(
    .LINES (LINES),
    .OW    (OW),
    .IW    (IW),
    .TW    (TW)
  ) u_array (
    .clk       (clk_i),
    .rst       (rst_i),
    .rd_idx    (req_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .store     (store),
    .fill      (fill),
    .wr_idx    (fill ? miss_line_q[IW-1:0] : req_idx),
    .wr_word   (req_word),
    .wr_data   (cpu_wdata_i),
    .fill_tag  (miss_line_q[IW +: TW]),
    .fill_line (mem_rdata_i)
  );

  // The missing line is latched so the CPU may drop its request mid-miss.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      miss_line_q <= '0;
      hit_cnt_o   <= '0;
      miss_cnt_o  <= '0;
    end else begin
      if (hit) hit_cnt_o <= hit_cnt_o + 32'd1;
      case (state)
        IDLE: begin
          if (cpu_req_i && !hit) begin
            miss_cnt_o  <= miss_cnt_o + 32'd1;
            miss_line_q <= {req_tag, req_idx};
            mem_req_o   <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state       <= WRITE_BACK;
              mem_we_o    <= 1'b1;
              mem_addr_o  <= {rd_tag, req_idx, {OW{1'b0}}};
              mem_wdata_o <= rd_line;
            end else begin
              state      <= ALLOCATE;
              mem_we_o   <= 1'b0;
              mem_addr_o <= {req_tag, req_idx, {OW{1'b0}}};
            end
          end
        end
        WRITE_BACK: begin
          if (mem_ack_i) begin
            state      <= ALLOCATE;
            mem_we_o   <= 1'b0;
            mem_addr_o <= {miss_line_q, {OW{1'b0}}};
          end
        end
        ALLOCATE: begin
          if (mem_ack_i) begin
            state     <= REFILL;
            mem_req_o <= 1'b0;
          end
        end
        REFILL: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: architectural memory model,
// direct-mapped residency model and a latency-programmable memory.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata_i;
  logic         mem_ack_i;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  always #5 clk = ~clk;

  dcache_ctrl #(.LINES(8), .LINE_BYTES(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
  );

  int vectors = 0;
  int errors  = 0;
  int lat     = 3;
  int mcnt    = 0;
  bit force_ack = 1'b0;

  // word address -> value, as the program sees it / as memory holds it
  logic [31:0] arch [int unsigned];
  logic [31:0] back [int unsigned];

  bit          mvalid [8];
  bit          mdirty [8];
  logic [24:0] mtag   [8];
  int unsigned mhit  = 0;
  int unsigned mmiss = 0;

  logic [31:0]  exp_wb_addr;
  logic [31:0]  exp_fill_addr;
  logic [127:0] last_wb = '0;
  logic [31:0]  last_wb_addr = '0;
  int           wb_seen = 0;
  int           fill_seen = 0;

  logic         prev_req = 1'b0;
  logic         prev_ack = 1'b0;
  logic         prev_we = 1'b0;
  logic [31:0]  prev_addr = '0;
  logic [127:0] prev_wdata = '0;

  function automatic logic [31:0] initval(logic [31:0] a);
    return ((a >> 2) * 32'h9E3779B1) ^ 32'h5;
  endfunction

  function automatic logic [31:0] aread(logic [31:0] wa);
    return arch.exists(wa) ? arch[wa] : initval(wa << 2);
  endfunction

  function automatic logic [31:0] bread(logic [31:0] wa);
    return back.exists(wa) ? back[wa] : initval(wa << 2);
  endfunction

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory: acks the lat-th cycle of a request, holds-checks the request.
  task automatic mem_step();
    if (mem_req_o) begin
      if (prev_req && !prev_ack) begin
        check("mem_hold_ctl", {mem_we_o, mem_addr_o},
              {prev_we, prev_addr});
        if (mem_we_o) check("mem_hold_data", mem_wdata_o, prev_wdata);
      end
      check("mem_align", mem_addr_o[3:0], 4'h0);
      mcnt++;
      if (mcnt >= lat) begin
        mem_ack_i = 1'b1;
        mcnt = 0;
        if (mem_we_o) begin
          check("wb_addr", mem_addr_o, exp_wb_addr);
          last_wb = mem_wdata_o;
          last_wb_addr = mem_addr_o;
          wb_seen++;
          for (int w = 0; w < 4; w++)
            back[(mem_addr_o >> 2) + w] = mem_wdata_o[32*w +: 32];
        end else begin
          check("fill_addr", mem_addr_o, exp_fill_addr);
          fill_seen++;
          for (int w = 0; w < 4; w++)
            mem_rdata_i[32*w +: 32] = bread((mem_addr_o >> 2) + w);
        end
      end else begin
        mem_ack_i = 1'b0;
        mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
      end
    end else begin
      mem_ack_i = force_ack;
      mcnt = 0;
      mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
    end
    prev_req   = mem_req_o;
    prev_ack   = mem_ack_i;
    prev_we    = mem_we_o;
    prev_addr  = mem_addr_o;
    prev_wdata = mem_wdata_o;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    mem_step();
    #1;
  endtask

  task automatic predict(input logic [31:0] addr, output bit hit,
                         output int est);
    logic [2:0]  idx;
    logic [24:0] tag;
    idx = addr[6:4];
    tag = addr[31:7];
    hit = mvalid[idx] && (mtag[idx] == tag);
    est = hit ? 0 : ((mvalid[idx] && mdirty[idx]) ? 2*lat + 2 : lat + 2);
    exp_wb_addr   = {mtag[idx], idx, 4'h0};
    exp_fill_addr = {addr[31:4], 4'h0};
    if (!hit) begin
      mmiss++;
      mvalid[idx] = 1'b1;
      mtag[idx]   = tag;
      mdirty[idx] = 1'b0;
    end
  endtask

  task automatic access(input bit we, input logic [31:0] addr,
                        input logic [31:0] wd, output int st,
                        output logic [31:0] rd);
    bit hit;
    int est;
    predict(addr, hit, est);
    cpu_req_i = 1'b1;
    cpu_we_i = we;
    cpu_addr_i = addr;
    cpu_wdata_i = wd;
    #1;
    st = 0;
    while (cpu_stall_o && st < 40) begin
      step();
      st++;
    end
    check("stall_cycles", st, est);
    rd = cpu_rdata_o;
    if (!we) check("load_data", rd, aread(addr >> 2));
    mhit++;
    if (we) begin
      arch[addr >> 2] = wd;
      mdirty[addr[6:4]] = 1'b1;
    end
    step();
    cpu_req_i = 1'b0;
    check("hit_cnt", hit_cnt_o, mhit);
    check("miss_cnt", miss_cnt_o, mmiss);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
    mhit = 0;
    mmiss = 0;
    arch = back;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int snap;
    logic [31:0] rd;
    logic [31:0] a;
    bit h;
    int est;

    rst_i = 1'b0;
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = '0;
    cpu_wdata_i = '0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    model_reset();
    step();
    step();
    check("rst_stall", cpu_stall_o, 1'b0);
    check("rst_rdata", cpu_rdata_o, 32'd0);
    check("rst_mem_req", {mem_req_o, mem_we_o}, 2'b00);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 128'd0);
    check("rst_cnts", {hit_cnt_o, miss_cnt_o}, 64'd0);
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    step();

    // cold load, latency 3
    lat = 3;
    access(1'b0, 32'h00, 32'h0, st, rd);
    check("cold_stall", st, 5);
    check("cold_data", rd, 32'd5);
    check("cold_miss", miss_cnt_o, 1);
    check("cold_hit", hit_cnt_o, 1);

    access(1'b0, 32'h04, 32'h0, st, rd);
    check("hit_stall", st, 0);
    check("hit_word1", rd, 32'h9E3779B4);
    check("hit_cnt2", hit_cnt_o, 2);

    // store hit, then conflicting load forces write-back
    access(1'b1, 32'h08, 32'h1234, st, rd);
    check("store_hit_stall", st, 0);
    access(1'b0, 32'h88, 32'h0, st, rd);
    check("wb_stall", st, 8);
    check("wb_line_addr", last_wb_addr, 32'h00);
    check("wb_word2", last_wb[95:64], 32'h1234);

    // stray acks while idle
    snap = wb_seen + fill_seen;
    force_ack = 1'b1;
    step();
    step();
    force_ack = 1'b0;
    step();
    check("idle_ack_hit", hit_cnt_o, 4);
    check("idle_ack_miss", miss_cnt_o, 2);
    check("idle_ack_req", mem_req_o, 1'b0);
    check("idle_ack_xfers", wb_seen + fill_seen, snap);
    access(1'b0, 32'h88, 32'h0, st, rd);
    check("idle_ack_rehit", st, 0);

    // store miss allocates without write-back, dirty kept until eviction
    snap = wb_seen;
    access(1'b1, 32'h100, 32'hCAFE, st, rd);
    check("store_miss_stall", st, 5);
    access(1'b0, 32'h100, 32'h0, st, rd);
    check("store_miss_rd", rd, 32'hCAFE);
    check("store_miss_nowb", wb_seen, snap);
    access(1'b0, 32'h180, 32'h0, st, rd);
    check("evict_stall", st, 8);
    check("evict_addr", last_wb_addr, 32'h100);
    check("evict_word0", last_wb[31:0], 32'hCAFE);

    // request dropped mid-miss still completes the fill
    snap = fill_seen;
    predict(32'h200, h, est);
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h200;
    #1;
    step();
    cpu_req_i = 1'b0;
    repeat (12) step();
    check("drop_fill", fill_seen, snap + 1);
    access(1'b0, 32'h200, 32'h0, st, rd);
    check("drop_rehit", st, 0);

    // reset during allocate
    access(1'b1, 32'h14, 32'hDEAD, st, rd);
    exp_fill_addr = 32'h300;
    cpu_req_i = 1'b1;
    cpu_we_i = 1'b0;
    cpu_addr_i = 32'h300;
    #1;
    step();
    step();
    check("alloc_active", {mem_req_o, mem_we_o}, 2'b10);
    rst_i = 1'b0;
    step();
    check("rst_mid_req", mem_req_o, 1'b0);
    check("rst_mid_stall", cpu_stall_o, 1'b0);
    check("rst_mid_rdata", cpu_rdata_o, 32'd0);
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    model_reset();
    step();
    check("rst_mid_cnts", {hit_cnt_o, miss_cnt_o}, 64'd0);
    access(1'b0, 32'h300, 32'h0, st, rd);
    check("rst_remiss", st, 5);
    check("rst_remiss_cnt", miss_cnt_o, 1);
    access(1'b0, 32'h14, 32'h0, st, rd);
    check("rst_lost_dirty", rd, initval(32'h14));

    // randomized traffic over 8 tags x 8 sets
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(1, 4);
      a = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
      access(1'($urandom_range(0, 1)), a, $urandom, st, rd);
      if ($urandom_range(0, 3) == 0) begin
        force_ack = 1'($urandom_range(0, 1));
        step();
        force_ack = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter LINES, default 8, number of direct-mapped cache lines (power of two).
REQ-002 Parameter LINE_BYTES, default 16, bytes per line (4 words).
REQ-003 clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-low.
REQ-005 cpu_req_i  input  1  MEM-stage access valid this cycle.
REQ-006 cpu_we_i  input  1  1 = store word, 0 = load word.
REQ-007 cpu_addr_i  input  32  byte address, word-aligned; bits [1:0] ignored.
REQ-008 cpu_wdata_i  input  32  store data.
REQ-009 cpu_rdata_o  output  32  load data, valid when cpu_req_i=1, cpu_we_i=0 and cpu_stall_o=0.
REQ-010 cpu_stall_o  output  1  freezes the pipeline (PC, IF/ID, ID/EX, EX/MEM hold).
REQ-011 mem_req_o  output  1  line transfer request to data memory.
REQ-012 mem_we_o  output  1  1 = line write-back, 0 = line fetch.
REQ-013 mem_addr_o  output  32  line-aligned byte address (low log2(LINE_BYTES) bits zero).
REQ-014 mem_wdata_o  output  8*LINE_BYTES  write-back line data.
REQ-015 mem_rdata_i  input  8*LINE_BYTES  fetched line, valid in the mem_ack_i cycle.
REQ-016 mem_ack_i  input  1  one-cycle pulse, transfer complete.
REQ-017 hit_cnt_o, miss_cnt_o  output  32 each  access statistics for the bench.

Function
REQ-018 Address split: offset = addr[log2(LINE_BYTES)-1:0], word select = addr[offset-1:2], index = next log2(LINES) bits, tag = remaining upper bits.
REQ-019 Hit = cpu_req_i & valid[index] & (tag[index] == addr tag) & state==IDLE.
REQ-020 Load hit: cpu_rdata_o driven combinationally from the selected word in the same cycle; cpu_stall_o=0.
REQ-021 Store hit: selected word written and dirty[index] set at the next rising edge; no stall; rest of the line unchanged.
REQ-022 cpu_stall_o = (cpu_req_i & ~hit) | (state != IDLE), combinational.
REQ-023 States IDLE, WRITE_BACK, ALLOCATE, REFILL.
REQ-024 IDLE -> WRITE_BACK on miss with the victim valid and dirty; IDLE -> ALLOCATE on miss with the victim clean or invalid.
REQ-025 WRITE_BACK: mem_req_o=1, mem_we_o=1, mem_addr_o = {victim tag, index, 0}, mem_wdata_o = victim line; -> ALLOCATE on mem_ack_i.
REQ-026 ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o = requested line address; on mem_ack_i: line data := mem_rdata_i, tag updated, valid=1, dirty=0; -> REFILL.
REQ-027 REFILL: one cycle, stall held; -> IDLE, where the stalled access retries and hits.
REQ-028 mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o held stable from request until the mem_ack_i cycle inclusive; mem_req_o=0 in IDLE and REFILL.
REQ-029 mem_ack_i outside WRITE_BACK/ALLOCATE is ignored.
REQ-030 cpu_req_i dropping mid-miss does not abort the transaction; the line is still filled.
REQ-031 Miss latency with clean victim = memory latency + 2 stall cycles; with dirty victim = 2 × memory latency + 2.
REQ-032 hit_cnt_o increments once per serviced access (each cycle with cpu_req_i=1 and hit=1); miss_cnt_o increments once per IDLE->WRITE_BACK/ALLOCATE transition; both wrap modulo 2^32.

Reset
REQ-033 With rst_i=0 at a rising edge: state=IDLE, all valid and dirty bits cleared, counters zero, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-034 cpu_rdata_o=0 and cpu_stall_o=0 during reset; tag and data arrays need not be cleared.
REQ-035 Reset mid-transaction abandons it; mem_req_o is 0 in the first cycle after reset; dirty data is lost.

Structure
REQ-036 Shared package dcache_pkg holds the state encoding, LINES/LINE_BYTES defaults, and derived OFFSET_W, INDEX_W, TAG_W constants.
REQ-037 Tag/valid/dirty/data storage is the sub-module dcache_array (1 combinational read port, 1 synchronous write port); the FSM and counters stay in dcache_ctrl.

Verification
REQ-038 Cold load 0x00, memory latency 3, mem_rdata_i word0=5 -> stall 5 cycles, then cpu_rdata_o=5, miss_cnt_o=1, hit_cnt_o=1.
REQ-039 Load 0x04 immediately after -> no stall, same-line word1 returned, hit_cnt_o=2.
REQ-040 Store 0x08 := 0x1234 (hit), then load 0x88 (same index, different tag) -> write-back at mem_addr_o=0x00 carrying 0x1234 in word2, then fetch at 0x80, stall 2×3+2=8 cycles.
REQ-041 mem_ack_i pulsed in IDLE -> no state, array, or counter change.
REQ-042 rst_i=0 during ALLOCATE -> mem_req_o=0 next cycle, load of the same address misses again afterwards.
REQ-043 Store miss 0x100 -> line fetched, then store applied on retry, dirty=1, no write-back before eviction.
